// File: rtl/handshake_constant_check.sv
// Consumer end of a constant-producing elastic channel: compares each input token to
// CONST_VALUE and forwards a one-bit match token through a one-entry output register.
module handshake_constant_check #(
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] CONST_VALUE = 32'h0001FB3C,
    parameter int          COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  ins,
    input  logic                   ins_valid,
    output logic                   ins_ready,
    output logic                   outs_match,
    output logic                   outs_valid,
    input  logic                   outs_ready,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] match_count,
    output logic [COUNT_WIDTH-1:0] mismatch_count,
    output logic                   error,
    output logic [DATA_WIDTH-1:0]  last_bad
);

    localparam logic [DATA_WIDTH-1:0]  EXPECTED  = DATA_WIDTH'(CONST_VALUE);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_t;

    slot_state_t state, state_next;
    logic        flag, flag_next;
    logic        full;
    logic        in_fire;
    logic        out_fire;
    logic        is_match;

    logic [COUNT_WIDTH-1:0] match_base, match_next;
    logic [COUNT_WIDTH-1:0] mismatch_base, mismatch_next;
    logic                   error_next;
    logic [DATA_WIDTH-1:0]  last_bad_next;

    // Ready passes straight through from downstream: a full slot can be replaced in the
    // same cycle it drains, so there is no need for a skid entry.
    assign full       = (state == SLOT_FULL);
    assign ins_ready  = !full || outs_ready;
    assign in_fire    = ins_valid && ins_ready;
    assign out_fire   = full && outs_ready;
    assign is_match   = (ins == EXPECTED);
    assign outs_valid = full;
    assign outs_match = flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SLOT_EMPTY;
            flag  <= 1'b0;
        end else begin
            state <= state_next;
            flag  <= flag_next;
        end
    end

    always_comb begin
        state_next = state;
        flag_next  = flag;
        case (state)
            SLOT_EMPTY: begin
                if (in_fire) begin
                    state_next = SLOT_FULL;
                    flag_next  = is_match;
                end
            end
            SLOT_FULL: begin
                if (in_fire) begin
                    flag_next = is_match;
                end else if (out_fire) begin
                    state_next = SLOT_EMPTY;
                end
            end
            default: begin
                state_next = SLOT_EMPTY;
                flag_next  = 1'b0;
            end
        endcase
    end

    // Clear is applied first so that a token accepted in the same cycle still counts.
    always_comb begin
        match_base    = clear ? '0 : match_count;
        mismatch_base = clear ? '0 : mismatch_count;
        match_next    = match_base;
        mismatch_next = mismatch_base;
        error_next    = clear ? 1'b0 : error;
        last_bad_next = clear ? '0 : last_bad;
        if (in_fire) begin
            if (is_match) begin
                if (match_base != COUNT_MAX) begin
                    match_next = match_base + COUNT_ONE;
                end
            end else begin
                if (mismatch_base != COUNT_MAX) begin
                    mismatch_next = mismatch_base + COUNT_ONE;
                end
                error_next    = 1'b1;
                last_bad_next = ins;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_count    <= '0;
            mismatch_count <= '0;
            error          <= 1'b0;
            last_bad       <= '0;
        end else begin
            match_count    <= match_next;
            mismatch_count <= mismatch_next;
            error          <= error_next;
            last_bad       <= last_bad_next;
        end
    end

endmodule
